// File: rtl/p2_grms_qsys_nios2_qsys_grms_oci_dct_packer.sv
// ---------------------------------------------------------------------------
// p2_grms_qsys_nios2_qsys_grms_oci_dct_packer
// Packs 6-bit CPU trace entries into 30-bit words (five entries per word).
// Completed or flushed words go through a 2-deep valid/ready FIFO. A small
// state machine handles the end-of-test handshake.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   trc_valid, trc_data   trace entry input (cannot be stalled)
//   flush                 push the partial word
//   test_ending           end-of-test request (acts as flush, then drains)
//   out_ready             downstream accepts the FIFO head
//   out_valid/out_data/out_count   FIFO head word and its entry count
//   dct_buffer/dct_count  live accumulator and number of entries in it
//   test_ending_o         high in ENDING and ENDED
//   test_has_ended        sticky, trace fully drained after test end
//   overflow_cnt          saturating count of words dropped on a full FIFO
// ---------------------------------------------------------------------------
module p2_grms_qsys_nios2_qsys_grms_oci_dct_packer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        trc_valid,
  input  logic [5:0]  trc_data,
  input  logic        flush,
  input  logic        test_ending,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [29:0] out_data,
  output logic [3:0]  out_count,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        test_ending_o,
  output logic        test_has_ended,
  output logic [7:0]  overflow_cnt
);

  localparam int unsigned ENTRY_W = 6;
  localparam int unsigned ENTRIES = 5;
  localparam int unsigned WORD_W  = 30;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned OVF_W   = 8;
  localparam int unsigned DEPTH   = 2;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_ENDING = 2'd1,
    ST_ENDED  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WORD_W-1:0]  r_buf;
  logic [CNT_W-1:0]   r_cnt;
  logic [WORD_W-1:0]  w_buf_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [WORD_W-1:0]  w_word;
  logic [CNT_W-1:0]   w_word_cnt;
  logic               w_push;

  logic [WORD_W-1:0]  r_mem_data [DEPTH];
  logic [CNT_W-1:0]   r_mem_cnt  [DEPTH];
  logic               r_rd_ptr;
  logic               r_wr_ptr;
  logic [1:0]         r_fcnt;
  logic [OVF_W-1:0]   r_ovf;
  logic               w_pop;
  logic               w_full;
  logic               w_wr_en;
  logic               w_drop;

  // Next state and accumulator update; the candidate word includes a
  // same-cycle entry so flush/test_ending push old+1 entries.
  always_comb begin
    w_state_nxt = r_state;
    w_word      = r_buf;
    w_word_cnt  = r_cnt;
    w_push      = 1'b0;
    w_buf_nxt   = r_buf;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_RUN: begin
        if (trc_valid) begin
          w_word[r_cnt*ENTRY_W +: ENTRY_W] = trc_data;
          w_word_cnt = r_cnt + 4'd1;
        end
        if ((w_word_cnt == CNT_W'(ENTRIES)) ||
            ((flush || test_ending) && (w_word_cnt != 4'd0))) begin
          w_push = 1'b1;
        end
        if (w_push) begin
          w_buf_nxt = '0;
          w_cnt_nxt = '0;
        end else begin
          w_buf_nxt = w_word;
          w_cnt_nxt = w_word_cnt;
        end
        if (test_ending) begin
          w_state_nxt = ST_ENDING;
        end
      end
      // Any push from the RUN->ENDING edge is already in the FIFO here.
      ST_ENDING: begin
        if (r_fcnt == 2'd0) begin
          w_state_nxt = ST_ENDED;
        end
      end
      default: begin
      end
    endcase
  end

  // FIFO control: a push in a pop cycle always lands, even when full.
  always_comb begin
    w_pop   = (r_fcnt != 2'd0) && out_ready;
    w_full  = (r_fcnt == 2'(DEPTH));
    w_wr_en = w_push && (!w_full || w_pop);
    w_drop  = w_push && w_full && !w_pop;
  end

  // State and accumulator registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_RUN;
      r_buf   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_buf   <= w_buf_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // FIFO storage, pointers, occupancy and overflow counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem_data[i] <= '0;
        r_mem_cnt[i]  <= '0;
      end
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_fcnt   <= '0;
      r_ovf    <= '0;
    end else begin
      if (w_wr_en) begin
        r_mem_data[r_wr_ptr] <= w_word;
        r_mem_cnt[r_wr_ptr]  <= w_word_cnt;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      if (w_wr_en && !w_pop) begin
        r_fcnt <= r_fcnt + 2'd1;
      end else if (!w_wr_en && w_pop) begin
        r_fcnt <= r_fcnt - 2'd1;
      end
      if (w_drop && (r_ovf != {OVF_W{1'b1}})) begin
        r_ovf <= r_ovf + 8'd1;
      end
    end
  end

  assign out_valid      = (r_fcnt != 2'd0);
  assign out_data       = r_mem_data[r_rd_ptr];
  assign out_count      = r_mem_cnt[r_rd_ptr];
  assign dct_buffer     = r_buf;
  assign dct_count      = r_cnt;
  assign test_ending_o  = (r_state != ST_RUN);
  assign test_has_ended = (r_state == ST_ENDED);
  assign overflow_cnt   = r_ovf;

endmodule
